// File: rtl/uart_rx_port_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default baud divisor.
// The transmit block is expected to import this package as well.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // 12 MHz system clock divided down to 115200 baud.
    localparam int UART_DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_rx_port_if.sv
// Bus between the UART receive port and Memory's peripheral decode.
// Memory is the master: it pops bytes and clears the sticky flags.
interface uart_rx_port_if;

    logic       pop;
    logic       clearErrors;
    logic [7:0] data;
    logic       dataValid;
    logic       overrun;
    logic       framingError;

    modport master (
        output pop,
        output clearErrors,
        input  data,
        input  dataValid,
        input  overrun,
        input  framingError
    );

    modport slave (
        input  pop,
        input  clearErrors,
        output data,
        output dataValid,
        output overrun,
        output framingError
    );

endinterface

// File: rtl/uart_rx_port_sync_fifo.sv
// Show-ahead synchronous FIFO. The head entry is presented combinationally
// and reads as zero when empty. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[PTR_W-1] != rdPtr[PTR_W-1]) &&
                   (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    assign headData = empty ? '0 : mem[rdPtr[ADDR_W-1:0]];

    // Storage is not reset; the empty check keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[ADDR_W-1:0]] <= pushData;
        end
    end

    // Pointer update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// UART 8N1 receive front end: synchronizes the rx pin, deframes characters,
// buffers them in a small FIFO for Memory, and keeps sticky overrun and
// framing-error flags for the status register.
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    uart_rx_port_if.slave   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxMeta;
    logic             rxs;
    logic             rxsPrev;

    rx_state_t        state;
    rx_state_t        nextState;
    logic [CNT_W-1:0] baudCnt;
    logic [CNT_W-1:0] nextBaudCnt;
    logic [2:0]       bitIndex;
    logic [2:0]       nextBitIndex;
    logic [7:0]       shiftReg;
    logic [7:0]       nextShiftReg;
    logic             baudDone;

    logic             fifoPush;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [7:0]       fifoHead;
    logic             setOverrun;
    logic             setFraming;
    logic             overrunReg;
    logic             framingReg;

    assign baudDone = (baudCnt == '0);

    // Two-flop synchronizer plus one delay stage for falling-edge detection; all idle high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxMeta  <= 1'b1;
            rxs     <= 1'b1;
            rxsPrev <= 1'b1;
        end else begin
            rxMeta  <= rx;
            rxs     <= rxMeta;
            rxsPrev <= rxs;
        end
    end

    // Receiver state, baud counter, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIndex <= '0;
            shiftReg <= '0;
        end else begin
            state    <= nextState;
            baudCnt  <= nextBaudCnt;
            bitIndex <= nextBitIndex;
            shiftReg <= nextShiftReg;
        end
    end

    // Next-state logic: only a true falling edge starts a frame, so a stuck-low line cannot retrigger.
    always_comb begin
        nextState    = state;
        nextBaudCnt  = baudCnt;
        nextBitIndex = bitIndex;
        nextShiftReg = shiftReg;
        fifoPush     = 1'b0;
        setOverrun   = 1'b0;
        setFraming   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rxsPrev && !rxs) begin
                    nextState   = START;
                    nextBaudCnt = HALF_LOAD;
                end
            end
            START: begin
                if (baudDone) begin
                    if (!rxs) begin
                        nextState    = DATA;
                        nextBaudCnt  = FULL_LOAD;
                        nextBitIndex = 3'd0;
                    end else begin
                        nextState = IDLE;
                    end
                end else begin
                    nextBaudCnt = baudCnt - 1'b1;
                end
            end
            DATA: begin
                if (baudDone) begin
                    nextShiftReg = {rxs, shiftReg[7:1]};
                    nextBaudCnt  = FULL_LOAD;
                    if (bitIndex == 3'd7) begin
                        nextState = STOP;
                    end else begin
                        nextBitIndex = bitIndex + 3'd1;
                    end
                end else begin
                    nextBaudCnt = baudCnt - 1'b1;
                end
            end
            STOP: begin
                if (baudDone) begin
                    nextState = IDLE;
                    if (rxs) begin
                        if (fifoFull && !bus.pop) begin
                            setOverrun = 1'b1;
                        end else begin
                            fifoPush = 1'b1;
                        end
                    end else begin
                        setFraming = 1'b1;
                    end
                end else begin
                    nextBaudCnt = baudCnt - 1'b1;
                end
            end
        endcase
    end

    // Sticky status flags; a clear wins over a set arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrunReg <= 1'b0;
            framingReg <= 1'b0;
        end else if (bus.clearErrors) begin
            overrunReg <= 1'b0;
            framingReg <= 1'b0;
        end else begin
            if (setOverrun) begin
                overrunReg <= 1'b1;
            end
            if (setFraming) begin
                framingReg <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) rxFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (nextShiftReg),
        .pop      (bus.pop),
        .headData (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign bus.data         = fifoHead;
    assign bus.dataValid    = !fifoEmpty;
    assign bus.overrun      = overrunReg;
    assign bus.framingError = framingReg;

endmodule

// File: doc/uart_rx_port.md
# uart_rx_port

Serial receive front end for the Machine's memory-mapped UART: it samples the `rx` pin, deframes 8N1 characters and buffers them in a small FIFO. The Memory block reads the head byte and pops it when the CPU loads the UART data address. It sits between the `rx` pad and Memory's peripheral decode. It also reports sticky overrun and framing-error flags for the UART status address.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clk cycles per bit (12 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4: receive buffer entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-low.
- `rx`  in  1: asynchronous serial input; idle high.
- `pop`  in  1: Memory consumed the head byte this cycle.
- `clearErrors`  in  1: clears both sticky flags.
- `data`  out  8: FIFO head byte; 8'h00 when the FIFO is empty.
- `dataValid`  out  1: FIFO not empty.
- `overrun`  out  1: sticky; a received byte was dropped because the FIFO was full.
- `framingError`  out  1: sticky; a stop bit was sampled low.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer; the flops reset to 1. The FSM uses only the synchronized value `rxs` and its one-cycle delay `rxsPrev`.
- **FSM states.**
  - IDLE: a falling edge (`rxsPrev`=1, `rxs`=0) loads the baud counter and moves to START. A low level without an edge is ignored, so a break or stuck-low line cannot retrigger reception.
  - START: after CLKS_PER_BIT/2 cycles (integer divide), sample `rxs`. If 0, go to DATA with bitIndex=0. If 1, treat it as a glitch and return to IDLE with no flags set.
  - DATA: every CLKS_PER_BIT cycles, sample `rxs` into the shift register LSB-first. After bitIndex 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - If 1: push the byte. If the FIFO is full and `pop` is not asserted in the same cycle, drop the byte and set `overrun`.
    - If 0: discard the byte and set `framingError`.
    - In both cases, return to IDLE.
- **Counter widths.** The baud counter is $clog2(CLKS_PER_BIT) bits and counts down to 0. The bit counter is 3 bits.
- **FIFO behaviour.**
  - Show-ahead: `data` is the head entry combinationally from the FIFO registers.
  - `pop` while empty is ignored.
  - Push and pop in the same cycle: both take effect. When full, this is not an overrun. When empty, the pushed byte becomes visible the next cycle and the pop is ignored.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap.
- **Sticky flags.**
  - `clearErrors` has priority over a set event in the same cycle.
  - Flags are independent of FIFO contents; `pop` does not clear them.
- **Reset.** Asserting `reset` (low at a clk edge) at any point, including mid-character, forces:
  - FSM to IDLE and counters to 0;
  - FIFO empty, `data`=0, `dataValid`=0;
  - both flags 0 and synchronizer flops to 1.

  A character in flight is lost. The next falling edge after reset releases starts a new frame.

## Timing
- A pin edge reaches `rxs` 2 cycles later.
- With the falling edge seen on `rxs` at cycle E:
  - start sample at E + CLKS_PER_BIT/2;
  - data bit k sample at E + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop sample at E + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- The FIFO write, `overrun` set and `framingError` set all register on the stop-sample edge. `dataValid` rises the cycle after the stop sample.
- `pop` at edge N: the next entry, or 0 and `dataValid`=0 if none, appears after edge N.
- A new start edge is accepted from the cycle after the stop sample. This tolerates sender clocks up to roughly half a bit fast over a frame.

## Structure
- **Package `uart_pkg`:**
  - `rx_state_t` enum {IDLE, START, DATA, STOP};
  - constant `UART_DEFAULT_CLKS_PER_BIT` = 104.
  - The future TX block shares this package.
- **Sub-module `sync_fifo`:** parameterised width and depth, show-ahead, with push/pop/full/empty. It is instantiated once here and reusable by TX.

## Test plan
Bench uses CLKS_PER_BIT=16 and FIFO_DEPTH=4.
- Send 8'hA5 as a clean 8N1 frame → `dataValid` rises 1 cycle after the stop sample; `data`=8'hA5; flags stay 0. After `pop`, `data`=0 and `dataValid`=0.
- Send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 with no pops → FIFO holds 01..04 and `overrun`=1.
  - Then pop 4 times → reads 01, 02, 03, 04.
  - `clearErrors` → `overrun`=0.
- Fill the FIFO with 4 bytes, then assert `pop` on exactly the stop-sample cycle of byte 5 (8'h55) → no overrun; pops return entries 2–4 then 8'h55.
- Drive a 5-cycle low glitch on `rx` → back to IDLE; no byte pushed; no flags set. Then send a frame with stop bit 0 and data 8'hFF → `framingError`=1; FIFO stays empty.
- Assert `reset` low for 1 cycle at mid-DATA of 8'h3C → all outputs 0. A subsequent full frame of 8'hC3 is received correctly.
- Hold `rx` low for 3 frame times, then release → at most one framing error; no repeated triggers. The next frame 8'h7E is received correctly.
